// File: rtl/mrv1_wb_arb.sv
// Writeback arbiter for the mrv1 core.
// Each functional unit gets a small circular FIFO that captures its result pulses.
// A round-robin arbiter drains the FIFOs into one output register, which drives the
// register-file write port through a valid/ready handshake. Per-FU stall flags
// throttle issue before a FIFO can overflow.
module mrv1_wb_arb #(
    parameter int NUM_FU_P        = 4,
    parameter int DATA_WIDTH_P    = 32,
    parameter int ITAG_WIDTH_P    = 3,
    parameter int NUM_THREADS_P   = 8,
    parameter int FIFO_DEPTH_P    = 4,
    // Enables the overflow assertion; a bench that overflows on purpose can clear it.
    parameter bit OVF_ASSERT_P    = 1'b1,
    localparam int TID_WIDTH_LP   = $clog2(NUM_THREADS_P),
    localparam int FU_ID_WIDTH_LP = $clog2(NUM_FU_P)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_FU_P-1:0]                exec_fu_done_i,
    input  logic [NUM_FU_P*DATA_WIDTH_P-1:0]   exec_fu_res_data_i,
    input  logic [NUM_FU_P*ITAG_WIDTH_P-1:0]   exec_fu_itag_i,
    input  logic [NUM_FU_P*TID_WIDTH_LP-1:0]   exec_fu_tid_i,
    output logic [NUM_FU_P-1:0]                wb_fu_stall_o,
    output logic                               wb_vld_o,
    input  logic                               wb_rdy_i,
    output logic [DATA_WIDTH_P-1:0]            wb_data_o,
    output logic [ITAG_WIDTH_P-1:0]            wb_itag_o,
    output logic [TID_WIDTH_LP-1:0]            wb_tid_o,
    output logic [FU_ID_WIDTH_LP-1:0]          wb_fu_id_o,
    output logic                               wb_ovf_o
);

    localparam int ENTRY_W_LP = DATA_WIDTH_P + ITAG_WIDTH_P + TID_WIDTH_LP;
    localparam int PTR_W_LP   = $clog2(FIFO_DEPTH_P);
    localparam int CNT_W_LP   = PTR_W_LP + 1;

    logic [NUM_FU_P-1:0]                 not_empty;
    logic [NUM_FU_P-1:0]                 push;
    logic [NUM_FU_P-1:0]                 pop;
    logic [NUM_FU_P-1:0]                 ovf_hit;
    logic [NUM_FU_P-1:0][ENTRY_W_LP-1:0] head;

    logic                                load;
    logic                                grant_vld;
    logic [FU_ID_WIDTH_LP-1:0]           grant;
    logic [FU_ID_WIDTH_LP-1:0]           cand;
    logic [FU_ID_WIDTH_LP-1:0]           rr_ptr_reg;

    // The output register may take a new entry when it is empty or being accepted.
    assign load = !wb_vld_o || wb_rdy_i;

    for (genvar gi = 0; gi < NUM_FU_P; gi++) begin : g_fu
        logic [ENTRY_W_LP-1:0] mem [FIFO_DEPTH_P];
        logic [PTR_W_LP-1:0]   rd_ptr_reg;
        logic [PTR_W_LP-1:0]   wr_ptr_reg;
        logic [CNT_W_LP-1:0]   count_reg;
        logic [CNT_W_LP-1:0]   count_next;
        logic                  stall_reg;
        logic                  full;

        assign full          = (count_reg == CNT_W_LP'(FIFO_DEPTH_P));
        assign not_empty[gi] = (count_reg != '0);
        assign pop[gi]       = load && grant_vld && (grant == FU_ID_WIDTH_LP'(gi));
        // A full FIFO still accepts a result when its head leaves in the same cycle.
        assign push[gi]      = exec_fu_done_i[gi] && (!full || pop[gi]);
        assign ovf_hit[gi]   = exec_fu_done_i[gi] && full && !pop[gi];
        assign head[gi]      = mem[rd_ptr_reg];
        assign wb_fu_stall_o[gi] = stall_reg;

        // Occupancy after this edge, used for both the count and the stall flag.
        always_comb begin
            count_next = count_reg;
            if (push[gi] && !pop[gi]) begin
                count_next = count_reg + CNT_W_LP'(1);
            end else if (!push[gi] && pop[gi]) begin
                count_next = count_reg - CNT_W_LP'(1);
            end
        end

        // Result storage; contents are don't-care while the FIFO is empty.
        always_ff @(posedge clk_i) begin
            if (push[gi]) begin
                mem[wr_ptr_reg] <= {exec_fu_res_data_i[gi*DATA_WIDTH_P +: DATA_WIDTH_P],
                                    exec_fu_itag_i[gi*ITAG_WIDTH_P +: ITAG_WIDTH_P],
                                    exec_fu_tid_i[gi*TID_WIDTH_LP +: TID_WIDTH_LP]};
            end
        end

        // Pointers, count and stall; stall leaves room for one result already in flight.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
                count_reg  <= '0;
                stall_reg  <= 1'b0;
            end else begin
                if (push[gi]) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_W_LP'(1);
                end
                if (pop[gi]) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_W_LP'(1);
                end
                count_reg <= count_next;
                stall_reg <= (count_next >= CNT_W_LP'(FIFO_DEPTH_P - 1));
            end
        end
    end

    // Round-robin search for the first non-empty FIFO starting at the pointer.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        cand      = '0;
        for (int i = 0; i < NUM_FU_P; i++) begin
            cand = FU_ID_WIDTH_LP'((int'(rr_ptr_reg) + i) % NUM_FU_P);
            if (!grant_vld && not_empty[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
    end

    // Output register, round-robin pointer and sticky overflow flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_vld_o   <= 1'b0;
            wb_data_o  <= '0;
            wb_itag_o  <= '0;
            wb_tid_o   <= '0;
            wb_fu_id_o <= '0;
            wb_ovf_o   <= 1'b0;
            rr_ptr_reg <= '0;
        end else begin
            if (load) begin
                if (grant_vld) begin
                    wb_vld_o <= 1'b1;
                    {wb_data_o, wb_itag_o, wb_tid_o} <= head[grant];
                    wb_fu_id_o <= grant;
                    rr_ptr_reg <= (grant == FU_ID_WIDTH_LP'(NUM_FU_P - 1)) ?
                                  '0 : grant + FU_ID_WIDTH_LP'(1);
                end else begin
                    wb_vld_o <= 1'b0;
                end
            end
            if (|ovf_hit) begin
                wb_ovf_o <= 1'b1;
            end
        end
    end

    // A dropped result is a protocol violation by issue; flag it in simulation.
    if (OVF_ASSERT_P) begin : g_ovf_chk
        a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i) ovf_hit == '0);
    end

endmodule

// File: tb/tb_mrv1_wb_arb.sv
// Directed testbench for mrv1_wb_arb: single result, simultaneous results,
// round-robin fairness, stall/backpressure, overflow and asynchronous reset.
module tb_mrv1_wb_arb;

    localparam int NFU = 4;
    localparam int DW  = 32;
    localparam int IW  = 3;
    localparam int TW  = 3;
    localparam int FW  = 2;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [NFU-1:0]    exec_fu_done_i;
    logic [NFU*DW-1:0] exec_fu_res_data_i;
    logic [NFU*IW-1:0] exec_fu_itag_i;
    logic [NFU*TW-1:0] exec_fu_tid_i;
    logic [NFU-1:0]    wb_fu_stall_o;
    logic              wb_vld_o;
    logic              wb_rdy_i;
    logic [DW-1:0]     wb_data_o;
    logic [IW-1:0]     wb_itag_o;
    logic [TW-1:0]     wb_tid_o;
    logic [FW-1:0]     wb_fu_id_o;
    logic              wb_ovf_o;

    int n_checks = 0;
    int n_errors = 0;

    mrv1_wb_arb #(
        .NUM_FU_P      (NFU),
        .DATA_WIDTH_P  (DW),
        .ITAG_WIDTH_P  (IW),
        .NUM_THREADS_P (8),
        .FIFO_DEPTH_P  (4),
        .OVF_ASSERT_P  (1'b0)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .exec_fu_done_i     (exec_fu_done_i),
        .exec_fu_res_data_i (exec_fu_res_data_i),
        .exec_fu_itag_i     (exec_fu_itag_i),
        .exec_fu_tid_i      (exec_fu_tid_i),
        .wb_fu_stall_o      (wb_fu_stall_o),
        .wb_vld_o           (wb_vld_o),
        .wb_rdy_i           (wb_rdy_i),
        .wb_data_o          (wb_data_o),
        .wb_itag_o          (wb_itag_o),
        .wb_tid_o           (wb_tid_o),
        .wb_fu_id_o         (wb_fu_id_o),
        .wb_ovf_o           (wb_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_fu(input int f, input logic [31:0] d, input logic [2:0] it, input logic [2:0] td);
        exec_fu_res_data_i[f*DW +: DW] = d;
        exec_fu_itag_i[f*IW +: IW]     = it;
        exec_fu_tid_i[f*TW +: TW]      = td;
    endtask

    task automatic check_wb(input string tag, input int fu, input logic [31:0] d,
                            input logic [2:0] it, input logic [2:0] td);
        $display("wb %s: vld=%0d fu=%0d data=0x%0h itag=%0d tid=%0d",
                 tag, wb_vld_o, wb_fu_id_o, wb_data_o, wb_itag_o, wb_tid_o);
        check_eq({tag, "_vld"},  32'(wb_vld_o), 32'd1);
        check_eq({tag, "_fu"},   32'(wb_fu_id_o), 32'(fu));
        check_eq({tag, "_data"}, wb_data_o, d);
        check_eq({tag, "_itag"}, 32'(wb_itag_o), 32'(it));
        check_eq({tag, "_tid"},  32'(wb_tid_o), 32'(td));
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_vld"},   32'(wb_vld_o), 32'd0);
        check_eq({tag, "_data"},  wb_data_o, 32'd0);
        check_eq({tag, "_itag"},  32'(wb_itag_o), 32'd0);
        check_eq({tag, "_tid"},   32'(wb_tid_o), 32'd0);
        check_eq({tag, "_fu"},    32'(wb_fu_id_o), 32'd0);
        check_eq({tag, "_stall"}, 32'(wb_fu_stall_o), 32'd0);
        check_eq({tag, "_ovf"},   32'(wb_ovf_o), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        exec_fu_done_i = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int sent [NFU];
        int got  [NFU];
        int exp_fu;
        int nrx;
        logic [5:0] stall_exp;
        logic [5:0] ovf_exp;
        logic [5:0] vld_exp;

        exec_fu_done_i     = '0;
        exec_fu_res_data_i = '0;
        exec_fu_itag_i     = '0;
        exec_fu_tid_i      = '0;
        wb_rdy_i           = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk_i);
        check_idle("reset");
        rst_i = 1'b1;
        @(negedge clk_i);
        check_idle("post_reset");

        // ---- single result, two-cycle latency, one-cycle valid ----
        wb_rdy_i = 1'b1;
        set_fu(0, 32'h1234, 3'd5, 3'd3);
        exec_fu_done_i = 4'b0001;
        @(negedge clk_i);
        exec_fu_done_i = '0;
        check_eq("t1_n1_vld", 32'(wb_vld_o), 32'd0);
        @(negedge clk_i);
        check_wb("t1", 0, 32'h1234, 3'd5, 3'd3);
        @(negedge clk_i);
        check_eq("t1_n3_vld", 32'(wb_vld_o), 32'd0);

        // ---- simultaneous FU0/FU1/FU3, pointer from 0 ----
        do_reset();
        for (int f = 0; f < NFU; f++) set_fu(f, 32'hA000 + 32'(f), 3'(f), 3'(f + 1));
        exec_fu_done_i = 4'b1011;
        @(negedge clk_i);
        exec_fu_done_i = '0;
        check_eq("t2_n1_vld", 32'(wb_vld_o), 32'd0);
        @(negedge clk_i);
        check_wb("t2_a", 0, 32'hA000, 3'd0, 3'd1);
        @(negedge clk_i);
        check_wb("t2_b", 1, 32'hA001, 3'd1, 3'd2);
        @(negedge clk_i);
        check_wb("t2_c", 3, 32'hA003, 3'd3, 3'd4);
        @(negedge clk_i);
        check_eq("t2_end_vld", 32'(wb_vld_o), 32'd0);
        // pointer wrapped to 0: FU0 beats FU1
        set_fu(0, 32'hB000, 3'd6, 3'd0);
        set_fu(1, 32'hB001, 3'd7, 3'd1);
        exec_fu_done_i = 4'b0011;
        @(negedge clk_i);
        exec_fu_done_i = '0;
        @(negedge clk_i);
        check_wb("t2_ptr_a", 0, 32'hB000, 3'd6, 3'd0);
        @(negedge clk_i);
        check_wb("t2_ptr_b", 1, 32'hB001, 3'd7, 3'd1);

        // ---- fairness: FU0 and FU2 pulse every cycle (honouring stall), pointer at 2 ----
        for (int f = 0; f < NFU; f++) begin
            sent[f] = 0;
            got[f]  = 0;
        end
        nrx    = 0;
        exp_fu = 2;
        for (int cyc = 0; cyc < 60 && nrx < 16; cyc++) begin
            exec_fu_done_i = '0;
            for (int f = 0; f < NFU; f += 2) begin
                if (sent[f] < 8 && !wb_fu_stall_o[f]) begin
                    set_fu(f, 32'h100 * 32'(f + 1) + 32'(sent[f]), 3'(sent[f]), 3'(f));
                    exec_fu_done_i[f] = 1'b1;
                    sent[f]++;
                end
            end
            @(negedge clk_i);
            exec_fu_done_i = '0;
            if (wb_vld_o) begin
                $display("wb t3: fu=%0d data=0x%0h", wb_fu_id_o, wb_data_o);
                check_eq("t3_fu", 32'(wb_fu_id_o), 32'(exp_fu));
                check_eq("t3_data", wb_data_o, 32'h100 * 32'(exp_fu + 1) + 32'(got[exp_fu]));
                got[exp_fu]++;
                nrx++;
                exp_fu = (exp_fu == 2) ? 0 : 2;
            end
        end
        check_eq("t3_received", 32'(nrx), 32'd16);
        check_eq("t3_ovf", 32'(wb_ovf_o), 32'd0);
        @(negedge clk_i);
        check_eq("t3_end_vld", 32'(wb_vld_o), 32'd0);

        // ---- backpressure, stall and overflow on FU1 ----
        do_reset();
        wb_rdy_i  = 1'b0;
        stall_exp = 6'b111000;
        ovf_exp   = 6'b100000;
        vld_exp   = 6'b111110;
        for (int k = 0; k < 6; k++) begin
            set_fu(1, 32'hC000 + 32'(k), 3'(k), 3'(7 - k));
            exec_fu_done_i = 4'b0010;
            @(negedge clk_i);
            exec_fu_done_i = '0;
            check_eq($sformatf("t4_stall%0d", k), 32'(wb_fu_stall_o),
                     stall_exp[k] ? 32'h2 : 32'h0);
            check_eq($sformatf("t4_ovf%0d", k), 32'(wb_ovf_o), 32'(ovf_exp[k]));
            check_eq($sformatf("t4_vld%0d", k), 32'(wb_vld_o), 32'(vld_exp[k]));
            if (k >= 1) check_eq($sformatf("t4_hold%0d", k), wb_data_o, 32'hC000);
        end
        wb_rdy_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_wb($sformatf("t5_drain%0d", k), 1, 32'hC000 + 32'(k), 3'(k), 3'(7 - k));
            @(negedge clk_i);
        end
        check_eq("t5_end_vld", 32'(wb_vld_o), 32'd0);
        check_eq("t5_ovf_sticky", 32'(wb_ovf_o), 32'd1);
        check_eq("t5_stall_clear", 32'(wb_fu_stall_o), 32'd0);

        // ---- asynchronous reset with entries buffered ----
        wb_rdy_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_fu(2, 32'hD000 + 32'(k), 3'(k), 3'(k));
            exec_fu_done_i = 4'b0100;
            @(negedge clk_i);
            exec_fu_done_i = '0;
        end
        check_wb("t6_pre", 2, 32'hD000, 3'd0, 3'd0);
        check_eq("t6_pre_stall", 32'(wb_fu_stall_o), 32'h4);
        #2;
        rst_i = 1'b0;
        #1;
        check_idle("t6_async");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i    = 1'b1;
        wb_rdy_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check_eq($sformatf("t6_no_stale%0d", k), 32'(wb_vld_o), 32'd0);
        end
        check_idle("t6_after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
